// File: rtl/round_judge.sv
// Purpose : judges one colour-prompt round at a time, with a shrinking answer window and a saturating score.
// Latency : outputs are registered and follow the state one cycle after the input event (LOAD and JUDGE each last one cycle).
// Backpr. : none; start is ignored while a round is running, and submit is ignored outside WAIT.
//
// Ports:
//   clock, resetn         single rising-edge clock; asynchronous active-low reset
//   start                 one-cycle pulse that begins a new game (accepted only in IDLE or OVER)
//   submit, answer[3:0]   one-cycle commit pulse and the player's colour switches
//   expected[3:0]         required colour mask; sampled only in JUDGE
//   new_round             one-cycle pulse on every LOAD cycle, used as the prompt LFSR enable
//   hit, miss             one-cycle result pulses
//   score[6:0]            correct-answer count, saturating at SCORE_MAX
//   busy, game_over       high in LOAD/WAIT/JUDGE, and high in OVER, respectively
module round_judge #(
  parameter int TIMEOUT_CYCLES = 100000000,
  parameter int STEP_CYCLES    = 5000000,
  parameter int MIN_CYCLES     = 25000000,
  parameter int SCORE_MAX      = 99
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic       submit,
  input  logic [3:0] answer,
  input  logic [3:0] expected,
  output logic       new_round,
  output logic       hit,
  output logic       miss,
  output logic [6:0] score,
  output logic       busy,
  output logic       game_over
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_W = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] STEP_W    = TW'(STEP_CYCLES);
  localparam logic [TW-1:0] MIN_W     = TW'(MIN_CYCLES);
  localparam logic [TW-1:0] ONE_W     = TW'(1);
  localparam logic [6:0]    SMAX_W    = 7'(SCORE_MAX);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WAIT  = 3'd2,
    JUDGE = 3'd3,
    OVER  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [TW-1:0] window_q, window_d;
  logic [3:0]    answer_q, answer_d;
  logic [6:0]    score_q, score_d;
  logic          new_round_q, new_round_d;
  logic          hit_q, hit_d;
  logic          miss_q, miss_d;
  logic          busy_q, busy_d;
  logic          game_over_q, game_over_d;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    window_d    = window_q;
    answer_d    = answer_q;
    score_d     = score_q;
    new_round_d = 1'b0;
    hit_d       = 1'b0;
    miss_d      = 1'b0;

    case (state_q)
      IDLE, OVER: begin
        if (start) begin
          state_d     = LOAD;
          score_d     = 7'd0;
          window_d    = TIMEOUT_W;
          new_round_d = 1'b1;
        end
      end
      LOAD: begin
        // Counting down to zero gives exactly window_q WAIT cycles.
        state_d = WAIT;
        timer_d = window_q - ONE_W;
      end
      WAIT: begin
        // A submit on the last (timer == 0) cycle still counts.
        if (submit) begin
          answer_d = answer;
          state_d  = JUDGE;
        end else if (timer_q == '0) begin
          state_d = OVER;
          miss_d  = 1'b1;
        end else begin
          timer_d = timer_q - ONE_W;
        end
      end
      JUDGE: begin
        if (answer_q == expected) begin
          state_d     = LOAD;
          hit_d       = 1'b1;
          new_round_d = 1'b1;
          if (score_q < SMAX_W) score_d = score_q + 7'd1;
          // Guard the subtraction so a small window never wraps around.
          if ((window_q >= STEP_W) && ((window_q - STEP_W) >= MIN_W))
            window_d = window_q - STEP_W;
          else
            window_d = MIN_W;
        end else begin
          state_d = OVER;
          miss_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d      = (state_d == LOAD) || (state_d == WAIT) || (state_d == JUDGE);
    game_over_d = (state_d == OVER);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      window_q    <= TIMEOUT_W;
      answer_q    <= 4'd0;
      score_q     <= 7'd0;
      new_round_q <= 1'b0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
      busy_q      <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      window_q    <= window_d;
      answer_q    <= answer_d;
      score_q     <= score_d;
      new_round_q <= new_round_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
      busy_q      <= busy_d;
      game_over_q <= game_over_d;
    end
  end

  assign new_round = new_round_q;
  assign hit       = hit_q;
  assign miss      = miss_q;
  assign score     = score_q;
  assign busy      = busy_q;
  assign game_over = game_over_q;

endmodule

// File: doc/round_judge.md
ROUND_JUDGE -- requirements
Module: round_judge

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 100000000, SHALL set the answer window of the first round in clock cycles (2 s at 50 MHz).
REQ-002 Parameter STEP_CYCLES, default 5000000, SHALL set the reduction of the answer window after each correct answer.
REQ-003 Parameter MIN_CYCLES, default 25000000, SHALL set the floor of the answer window.
REQ-004 Parameter SCORE_MAX, default 99, SHALL set the score saturation value (at most 127).
REQ-005 clock  input  1  SHALL be the single clock (CLOCK_50 at top level); all state changes on its rising edge.
REQ-006 resetn  input  1  SHALL be an asynchronous, active-low reset.
REQ-007 start  input  1  SHALL be a one-cycle pulse that begins a new game.
REQ-008 submit  input  1  SHALL be a one-cycle pulse (debounced KEY edge) that commits the player answer.
REQ-009 answer  input  4  SHALL carry the player colour switches SW[3:0].
REQ-010 expected  input  4  SHALL carry the required colour mask from the prompt generator (not/not-not output).
REQ-011 new_round  output  1  SHALL be a one-cycle pulse that drives the prompt LFSR enable.
REQ-012 hit, miss  output  1 each  SHALL be one-cycle result pulses.
REQ-013 score  output  7  SHALL be the current correct-answer count.
REQ-014 busy  output  1  SHALL be high in states LOAD, WAIT and JUDGE.
REQ-015 game_over  output  1  SHALL be high in state OVER.

Function
REQ-016 The FSM SHALL have states IDLE, LOAD, WAIT, JUDGE, OVER.
REQ-017 IDLE or OVER with start=1 SHALL go to LOAD next cycle, clear score to 0, and reload the window register with TIMEOUT_CYCLES.
REQ-018 start SHALL be ignored in LOAD, WAIT and JUDGE.
REQ-019 LOAD SHALL last exactly one cycle, with new_round=1 for that cycle, then go to WAIT with timer = window-1.
REQ-020 In WAIT the timer SHALL decrement by 1 per cycle.
REQ-021 WAIT with submit=1 SHALL register answer into answer_q and go to JUDGE.
REQ-022 WAIT with submit=0 and timer=0 SHALL go to OVER with miss=1 on the entry cycle.
REQ-023 WAIT with submit=1 and timer=0 in the same cycle SHALL treat the submit as valid; submit wins.
REQ-024 submit outside WAIT SHALL be ignored.
REQ-025 JUDGE SHALL last one cycle and compare answer_q to expected bitwise over all 4 bits.
REQ-026 On a match, the block SHALL go to LOAD, pulse hit on the LOAD cycle, and increment score, saturating at SCORE_MAX.
REQ-027 On a match, the window SHALL become max(window-STEP_CYCLES, MIN_CYCLES) without underflow.
REQ-028 On a mismatch, the block SHALL go to OVER and pulse miss on the entry cycle; score SHALL hold.
REQ-029 expected SHALL be sampled only in JUDGE; upstream SHALL hold it stable from the cycle after new_round.
REQ-030 The timer and window widths SHALL be $clog2(TIMEOUT_CYCLES+1) bits.
REQ-031 All outputs SHALL be registered.

Reset
REQ-032 resetn=0 SHALL immediately force state IDLE, score=0, timer=0, window=TIMEOUT_CYCLES, answer_q=0, and new_round=hit=miss=busy=game_over=0.
REQ-033 Reset asserted mid-round SHALL abandon the round with no hit or miss pulse.
REQ-034 After reset release, the block SHALL stay in IDLE until start.

Verification (TIMEOUT_CYCLES=20, STEP_CYCLES=4, MIN_CYCLES=8, SCORE_MAX=3)
REQ-035 start; expected=4'b0101; submit with answer=4'b0101 on WAIT cycle 3 -> JUDGE, then hit and new_round on the same cycle, score=1, next window=16.
REQ-036 start; no submit -> miss and game_over exactly 20 cycles after WAIT entry, score=0, busy=0.
REQ-037 Five consecutive correct answers -> score sequence 1,2,3,3,3 and windows 16,12,8,8,8.
REQ-038 submit on the WAIT cycle where timer=0, matching answer -> hit, no miss; mismatching answer -> miss once.
REQ-039 resetn low during WAIT with timer=7 -> IDLE immediately, all outputs 0; submit afterwards ignored; start -> new_round after one cycle.
REQ-040 From OVER with score=2, start -> score=0, window=20, new_round next cycle.
